// File: rtl/ysyx_22050019_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050019_pipe_pkg
//  Purpose  : Shared widths and sideband field layout for NPC pipeline stage
//             registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Revision : 1.0  initial release
// ============================================================================
package ysyx_22050019_pipe_pkg;

  // Default payload widths used by every stage register
  localparam int PC_W_D   = 64;
  localparam int INST_W_D = 32;
  localparam int SIDE_W_D = 8;

  // Bit positions inside the default 8-bit sideband bundle
  typedef enum int unsigned {
    SIDE_COMMIT       = 0,
    SIDE_EXC_VALID    = 1,
    SIDE_EXC_CODE_LSB = 2
  } side_bit_e;

  localparam int SIDE_EXC_CODE_W = 6;

  // Structured view of the default sideband bundle (LSB = commit)
  typedef struct packed {
    logic [SIDE_EXC_CODE_W-1:0] exc_code;
    logic                       exc_valid;
    logic                       commit;
  } side_t;

endpackage : ysyx_22050019_pipe_pkg
`default_nettype wire

// File: rtl/ysyx_22050019_pipe_slot.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050019_pipe_slot
//  Purpose  : One valid flag plus payload register. clr (flush) zeroes both,
//             load captures d and sets valid, drop clears valid only so the
//             payload holds its last value while the slot is a bubble.
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_22050019_pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         drop,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Valid/payload register: reset and clear zero everything, load wins over drop
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= d;
    end else if (drop) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign q     = r_data;

endmodule : ysyx_22050019_pipe_slot
`default_nettype wire

// File: rtl/ysyx_22050019_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050019_pipe_stage
//  Purpose  : Parametrised valid/ready pipeline stage register carrying pc,
//             instruction and sideband. Supports stall, flush and an optional
//             skid slot that registers in_ready_o to cut ready chains.
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_22050019_pipe_stage
  import ysyx_22050019_pipe_pkg::*;
#(
  parameter int PC_W    = PC_W_D,
  parameter int INST_W  = INST_W_D,
  parameter int SIDE_W  = SIDE_W_D,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PC_W-1:0]   in_pc_i,
  input  logic [INST_W-1:0] in_inst_i,
  input  logic [SIDE_W-1:0] in_side_i,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   out_pc_o,
  output logic [INST_W-1:0] out_inst_o,
  output logic [SIDE_W-1:0] out_side_o,
  output logic              skid_full_o
);

  localparam int c_DATA_W = PC_W + INST_W + SIDE_W;

  logic                w_dn_rdy;
  logic                w_out_fire;
  logic                w_in_fire;
  logic [c_DATA_W-1:0] w_in_data;
  logic                w_main_valid;
  logic [c_DATA_W-1:0] w_main_data;
  logic                w_main_load;
  logic                w_main_drop;
  logic [c_DATA_W-1:0] w_main_d;

  assign w_dn_rdy   = out_ready_i & ~stall_i;
  assign w_out_fire = w_main_valid & w_dn_rdy;
  assign w_in_fire  = in_valid_i & in_ready_o;
  assign w_in_data  = {in_pc_i, in_inst_i, in_side_i};

  // Main slot always drives the output side
  ysyx_22050019_pipe_slot #(.W(c_DATA_W)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush_i),
    .load  (w_main_load),
    .drop  (w_main_drop),
    .d     (w_main_d),
    .valid (w_main_valid),
    .q     (w_main_data)
  );

  generate
    if (SKID_EN) begin : g_skid
      logic                w_skid_valid;
      logic [c_DATA_W-1:0] w_skid_data;
      logic                w_skid_load;
      logic                w_skid_drop;

      // Ready comes straight from the skid valid flop, so it is registered
      assign in_ready_o  = ~w_skid_valid;
      assign skid_full_o = w_skid_valid;

      // Steering: the skid beat is older than the input beat, so it refills main first
      always_comb begin
        w_main_load = 1'b0;
        w_main_drop = 1'b0;
        w_main_d    = w_in_data;
        w_skid_load = 1'b0;
        w_skid_drop = 1'b0;
        if (!w_main_valid || w_out_fire) begin
          if (w_skid_valid) begin
            w_main_load = 1'b1;
            w_main_d    = w_skid_data;
            w_skid_load = w_in_fire;
            w_skid_drop = ~w_in_fire;
          end else begin
            w_main_load = w_in_fire;
            w_main_drop = ~w_in_fire;
          end
        end else begin
          w_skid_load = w_in_fire;
        end
      end

      ysyx_22050019_pipe_slot #(.W(c_DATA_W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush_i),
        .load  (w_skid_load),
        .drop  (w_skid_drop),
        .d     (w_in_data),
        .valid (w_skid_valid),
        .q     (w_skid_data)
      );
    end else begin : g_no_skid
      // Single entry: accept whenever main is empty or draining this cycle
      assign in_ready_o  = ~w_main_valid | w_dn_rdy;
      assign skid_full_o = 1'b0;

      // Main loads every accepted beat and empties when it drains with nothing behind it
      always_comb begin
        w_main_d    = w_in_data;
        w_main_load = w_in_fire;
        w_main_drop = w_out_fire & ~w_in_fire;
      end
    end
  endgenerate

  assign out_valid_o = w_main_valid;
  assign out_pc_o    = w_main_data[c_DATA_W-1 -: PC_W];
  assign out_inst_o  = w_main_data[SIDE_W +: INST_W];
  assign out_side_o  = w_main_data[SIDE_W-1:0];

endmodule : ysyx_22050019_pipe_stage
`default_nettype wire
